// File: rtl/logic_acc_pkg.sv
// ---------------------------------------------------------------------------
// logic_acc_pkg
// Shared definitions for the logic accumulator pipe:
//   op_e    : 2-bit bitwise op encoding carried on in_op
//   state_e : controller states of logic_acc_pipe
// ---------------------------------------------------------------------------
package logic_acc_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC  = 2'b01,
      ST_OUT  = 2'b10
   } state_e;

endpackage : logic_acc_pkg

// File: rtl/logic_acc_fold.sv
// ---------------------------------------------------------------------------
// logic_acc_fold
// Combinational fold step: next accumulator = acc OP in_a.
// NAND folds as AND; the final inversion is applied once, when the result
// is presented, so a multi-beat NAND is ~(a0 & a1 & ... & an).
//
// Ports:
//   acc     in  WIDTH  current accumulator
//   in_a    in  WIDTH  incoming operand
//   op      in  op_e   burst operation
//   acc_nxt out WIDTH  folded value
// ---------------------------------------------------------------------------
module logic_acc_fold
   import logic_acc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] in_a,
   input  op_e              op,
   output logic [WIDTH-1:0] acc_nxt
);

   always_comb begin
      acc_nxt = acc & in_a;
      unique case (op)
         OP_AND,
         OP_NAND: acc_nxt = acc & in_a;
         OP_OR:   acc_nxt = acc | in_a;
         OP_XOR:  acc_nxt = acc ^ in_a;
         default: acc_nxt = acc & in_a;
      endcase
   end

endmodule : logic_acc_fold

// File: rtl/logic_acc_pipe.sv
// ---------------------------------------------------------------------------
// logic_acc_pipe
// Folds a burst of WIDTH-bit operands with AND/OR/XOR/NAND and presents the
// result on a valid/ready output together with the (saturating) beat count.
//
// Optional build macro: LOGIC_ACC_ZFLAG_EN adds output y_zero = (y == 0),
// registered and held together with y.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      operand beat offered
//   in_ready  out  1      beat accepted this cycle when in_valid is high
//   in_a      in   WIDTH  operand
//   in_op     in   2      op, sampled on the first beat of a burst only
//   in_last   in   1      final beat of burst
//   y_valid   out  1      result available
//   y_ready   in   1      consumer takes result
//   y         out  WIDTH  folded result
//   y_cnt     out  CNT_W  beats in burst, saturated at 2^CNT_W-1
//   y_zero    out  1      (LOGIC_ACC_ZFLAG_EN only) y == 0
//   y_ovf     out  1      burst exceeded 2^CNT_W-1 beats
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for the first beat; captures operand and op
// ST_ACC  | folding further beats; gaps allowed, in_op ignored
// ST_OUT  | result presented and held until y_valid && y_ready
// ---------------------------------------------------------------------------
module logic_acc_pipe
   import logic_acc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [1:0]       in_op,
   input  logic             in_last,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [WIDTH-1:0] y,
   output logic [CNT_W-1:0] y_cnt,
`ifdef LOGIC_ACC_ZFLAG_EN
   output logic             y_zero,
`endif
   output logic             y_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state;
   logic [WIDTH-1:0] acc;
   op_e              op_q;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             beat;
   op_e              op_in;
   logic [WIDTH-1:0] acc_fold;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic [WIDTH-1:0] y_first;
   logic [WIDTH-1:0] y_acc;

   assign beat  = in_valid && in_ready;
   assign op_in = op_e'(in_op);

   logic_acc_fold #(
      .WIDTH (WIDTH)
   ) u_fold (
      .acc     (acc),
      .in_a    (in_a),
      .op      (op_q),
      .acc_nxt (acc_fold)
   );

   // Counter holds at max; the first beat that would wrap sets the sticky flag.
   always_comb begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      ovf_nxt = ovf | (cnt == CNT_MAX);
   end

   // Presented result: NAND is the only op that inverts, applied at the end.
   always_comb begin
      y_first = in_a     ^ {WIDTH{op_in == OP_NAND}};
      y_acc   = acc_fold ^ {WIDTH{op_q  == OP_NAND}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         op_q     <= OP_AND;
         cnt      <= '0;
         ovf      <= 1'b0;
         in_ready <= 1'b1;
         y_valid  <= 1'b0;
         y        <= '0;
         y_cnt    <= '0;
         y_ovf    <= 1'b0;
`ifdef LOGIC_ACC_ZFLAG_EN
         y_zero   <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (beat) begin
                  acc  <= in_a;
                  op_q <= op_in;
                  cnt  <= CNT_ONE;
                  ovf  <= 1'b0;
                  if (in_last) begin
                     state    <= ST_OUT;
                     in_ready <= 1'b0;
                     y_valid  <= 1'b1;
                     y        <= y_first;
                     y_cnt    <= CNT_ONE;
                     y_ovf    <= 1'b0;
`ifdef LOGIC_ACC_ZFLAG_EN
                     y_zero   <= (y_first == '0);
`endif
                  end else begin
                     state <= ST_ACC;
                  end
               end
            end

            ST_ACC: begin
               if (beat) begin
                  acc <= acc_fold;
                  cnt <= cnt_nxt;
                  ovf <= ovf_nxt;
                  if (in_last) begin
                     state    <= ST_OUT;
                     in_ready <= 1'b0;
                     y_valid  <= 1'b1;
                     y        <= y_acc;
                     y_cnt    <= cnt_nxt;
                     y_ovf    <= ovf_nxt;
`ifdef LOGIC_ACC_ZFLAG_EN
                     y_zero   <= (y_acc == '0);
`endif
                  end
               end
            end

            ST_OUT: begin
               // Result registers stay put; only the handshake flags move.
               if (y_ready) begin
                  state    <= ST_IDLE;
                  in_ready <= 1'b1;
                  y_valid  <= 1'b0;
               end
            end

            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
               y_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule : logic_acc_pipe

// File: tb/tb_logic_acc_pipe.sv
module tb_logic_acc_pipe;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [1:0]       in_op;
   logic             in_last;
   logic             y_valid;
   logic             y_ready;
   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] y_cnt;
   logic             y_ovf;
`ifdef LOGIC_ACC_ZFLAG_EN
   logic             y_zero;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] bq_data[$];
   logic [1:0]       bq_op[$];

   logic_acc_pipe #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_op    (in_op),
      .in_last  (in_last),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y        (y),
      .y_cnt    (y_cnt),
`ifdef LOGIC_ACC_ZFLAG_EN
      .y_zero   (y_zero),
`endif
      .y_ovf    (y_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: fold the burst with the op of the first beat, invert once for NAND.
   function automatic logic [WIDTH-1:0] model_y();
      logic [WIDTH-1:0] r;
      logic [1:0]       op;
      r  = bq_data[0];
      op = bq_op[0];
      for (int i = 1; i < bq_data.size(); i++) begin
         case (op)
            2'd1:    r = r | bq_data[i];
            2'd2:    r = r ^ bq_data[i];
            default: r = r & bq_data[i];
         endcase
      end
      if (op == 2'd3) r = ~r;
      return r;
   endfunction

   // Offer one beat at a negedge; it is taken at the next posedge if in_ready.
   task automatic feed_beat(input logic [WIDTH-1:0] a, input logic [1:0] op, input logic last);
      bit taken = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_op    = op;
      in_last  = last;
      for (int t = 0; t < 20 && !taken; t++) begin
         taken = (in_ready === 1'b1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!taken) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_burst(input string tag, input int hold, input int gap_max);
      int               n;
      logic [WIDTH-1:0] exp_y;
      int               exp_cnt;
      logic             exp_ovf;
      n       = bq_data.size();
      exp_y   = model_y();
      exp_cnt = (n > CNT_MAX) ? CNT_MAX : n;
      exp_ovf = (n > CNT_MAX);
      y_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         feed_beat(bq_data[i], bq_op[i], (i == n - 1));
      end
      check({tag, "_y_valid"},  32'(y_valid),  32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_y"},        32'(y),        32'(exp_y));
      check({tag, "_y_cnt"},    32'(y_cnt),    32'(exp_cnt));
      check({tag, "_y_ovf"},    32'(y_ovf),    32'(exp_ovf));
`ifdef LOGIC_ACC_ZFLAG_EN
      check({tag, "_y_zero"},   32'(y_zero),   32'(exp_y == '0));
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_a     = WIDTH'($urandom);
         in_op    = 2'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
         check({tag, "_hold_y"},        32'(y),        32'(exp_y));
         check({tag, "_hold_y_cnt"},    32'(y_cnt),    32'(exp_cnt));
         check({tag, "_hold_y_valid"},  32'(y_valid),  32'd1);
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      y_ready  = 1'b1;
      @(negedge clk);
      y_ready  = 1'b0;
      check({tag, "_post_y_valid"},  32'(y_valid),  32'd0);
      check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_op    = '0;
      in_last  = 1'b0;
      y_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_y_valid",  32'(y_valid),  32'd0);
      check("rst_y",        32'(y),        32'd0);
      check("rst_y_cnt",    32'(y_cnt),    32'd0);
      check("rst_y_ovf",    32'(y_ovf),    32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of an AND burst.
      feed_beat(8'hF0, 2'd0, 1'b0);
      feed_beat(8'h3C, 2'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midacc_rst_y_valid",  32'(y_valid),  32'd0);
      check("midacc_rst_y",        32'(y),        32'd0);
      check("midacc_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      bq_data = '{8'hFF, 8'hF0, 8'h3C}; bq_op = '{2'd0, 2'd0, 2'd0};
      run_burst("and3", 0, 0);
      bq_data = '{8'hA5}; bq_op = '{2'd3};
      run_burst("nand1", 0, 0);
      bq_data = '{8'h0F, 8'hFF}; bq_op = '{2'd2, 2'd1};
      run_burst("xor_opchg", 0, 0);
      bq_data = '{8'h12, 8'h34}; bq_op = '{2'd2, 2'd2};
      run_burst("xor_stall", 5, 0);
      bq_data = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10}; bq_op = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      run_burst("or_ovf", 0, 1);
      bq_data = '{8'h0F, 8'hF0}; bq_op = '{2'd0, 2'd0};
      run_burst("and_zero", 0, 0);
      bq_data = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; bq_op = '{2'd0, 2'd2, 2'd1, 2'd0};
      run_burst("and_sat_exact", 1, 0);

      // Reset while a result is presented.
      feed_beat(8'h77, 2'd1, 1'b1);
      check("midout_y_valid", 32'(y_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midout_rst_y_valid",  32'(y_valid),  32'd0);
      check("midout_rst_y",        32'(y),        32'd0);
      check("midout_rst_y_cnt",    32'(y_cnt),    32'd0);
      check("midout_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int b = 0; b < 40; b++) begin
         int n;
         n = $urandom_range(6, 1);
         bq_data.delete();
         bq_op.delete();
         for (int i = 0; i < n; i++) begin
            bq_data.push_back(WIDTH'($urandom));
            bq_op.push_back(2'($urandom));
         end
         run_burst($sformatf("rnd%0d", b), $urandom_range(3, 0), 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_logic_acc_pipe
